// File: rtl/writeback_regfile_pkg.sv
// Shared processor package: datapath/address defaults, the hard-wired zero
// register index and the pipeline-register widths that depend on them.
package writeback_regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_IDX = 0;

  // Widths of the pipeline registers feeding this block
  localparam int MEMWB_CTRL_W = 2;  // RegWrite, MemtoReg
  localparam int MEMWB_W      = MEMWB_CTRL_W + 2 * DATA_W_DEF + ADDR_W_DEF;
  localparam int EXMEM_W      = MEMWB_CTRL_W + 1 + 2 * DATA_W_DEF + ADDR_W_DEF;

endpackage

// File: rtl/writeback_mux.sv
// Writeback result select; shared with the execute-stage forwarding path.
module writeback_mux
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              mem_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = mem_sel ? mem_data : alu_result;
  end

endmodule

// File: rtl/writeback_regfile.sv
// Two-read, one-write register file with r0 hard-wired to zero,
// write-before-read bypass and a committed-write counter.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic [DATA_W-1:0] ALUResultW,
  input  logic [DATA_W-1:0] DMReadDataW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] ResultW,
  output logic [31:0]       WBCount
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(ZERO_REG_IDX);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [31:0]       wbcount_q;
  logic [31:0]       wbcount_d;
  logic              wr_en;

  writeback_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .mem_sel    (MemtoRegW),
    .alu_result (ALUResultW),
    .mem_data   (DMReadDataW),
    .result     (ResultW)
  );

  always_comb begin
    wr_en = RegWriteW && (WriteRegW != ZERO_REG);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[WriteRegW] = ResultW;
    regs_d[ZERO_REG_IDX] = '0;
  end

  always_comb begin
    wbcount_d = wbcount_q + (wr_en ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      wbcount_q <= '0;
    end else begin
      regs_q    <= regs_d;
      wbcount_q <= wbcount_d;
    end
  end

  // Bypass is held off during reset so reads then see only the cleared array
  always_comb begin
    RD1D = regs_q[RA1D];
    RD2D = regs_q[RA2D];
    if (!rst && wr_en && (RA1D == WriteRegW)) RD1D = ResultW;
    if (!rst && wr_en && (RA2D == WriteRegW)) RD2D = ResultW;
    if (RA1D == ZERO_REG) RD1D = '0;
    if (RA2D == ZERO_REG) RD2D = '0;
  end

  assign WBCount = wbcount_q;

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_W, default 32: register and datapath width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width (2**ADDR_W registers).
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 RegWriteW  input  1: writeback enable from the memory/writeback pipeline register.
REQ-006 MemtoRegW  input  1: result select; 1 selects memory read data, 0 selects the ALU result.
REQ-007 ALUResultW  input  DATA_W: ALU result in the writeback stage.
REQ-008 DMReadDataW  input  DATA_W: data-memory read data in the writeback stage.
REQ-009 WriteRegW  input  ADDR_W: destination register number.
REQ-010 RA1D  input  ADDR_W: decode-stage read address, port 1.
REQ-011 RA2D  input  ADDR_W: decode-stage read address, port 2.
REQ-012 RD1D  output  DATA_W: read data, port 1.
REQ-013 RD2D  output  DATA_W: read data, port 2.
REQ-014 ResultW  output  DATA_W: selected writeback value, exported for execute-stage forwarding.
REQ-015 WBCount  output  32: count of committed register writes.

Function
REQ-016 ResultW SHALL equal DMReadDataW when MemtoRegW=1, else ALUResultW.
- Purely combinational; valid regardless of RegWriteW.
REQ-017 The block SHALL hold 2**ADDR_W registers of DATA_W bits.
REQ-018 An effective write SHALL occur when RegWriteW=1 and WriteRegW!=0.
- Writes ResultW into register WriteRegW on the rising clk edge.
REQ-019 Register 0 SHALL read as zero on both ports at all times; writes to register 0 are discarded.
REQ-020 RD1D/RD2D SHALL be combinational reads of the register addressed by RA1D/RA2D.
REQ-021 Same-cycle write/read conflict: when an effective write is pending and RAnD==WriteRegW (nonzero), RDnD SHALL return ResultW, not the stale array value.
- This is the write-before-read bypass; zero added latency.
REQ-022 Both read ports SHALL operate independently and simultaneously.
- Both SHALL bypass when both addresses equal WriteRegW.
REQ-023 WBCount SHALL increment by 1 on each rising edge with an effective write.
- Writes to register 0 and cycles with RegWriteW=0 do not increment.
REQ-024 WBCount SHALL wrap from 0xFFFFFFFF to 0x00000000 without saturation or flag.
REQ-025 X or unknown on RegWriteW while rst=1 SHALL have no effect on state.

Reset
REQ-026 While rst=1, all registers and WBCount SHALL be asynchronously forced to 0, independent of clk.
REQ-027 A write coincident with reset assertion SHALL be lost; the register reads 0.
REQ-028 Reads during reset SHALL return 0, except that bypass on RD1D/RD2D is suppressed while rst=1.
REQ-029 The first effective write SHALL be accepted on the first rising clk edge after rst deasserts.

Structure
REQ-030 DATA_W/ADDR_W defaults and the zero-register index constant SHALL live in the shared processor package, alongside the pipeline-register widths.
REQ-031 The writeback mux SHALL be a separate sub-module, writeback_mux.
- It is reused by the forwarding path.
- Register array, bypass and counter stay in writeback_regfile.

Verification
REQ-032 Reset: assert rst mid-run after writing 0xDEADBEEF to r5 -> RD1D(RA1D=5)=0 immediately, and WBCount=0.
REQ-033 Mux and write:
- Inputs: MemtoRegW=1, DMReadDataW=0x12345678, ALUResultW=0xAAAA5555, RegWriteW=1, WriteRegW=9.
- Expected: ResultW=0x12345678; after the edge, RD2D(RA2D=9)=0x12345678 and WBCount=1.
REQ-034 Register 0:
- Inputs: RegWriteW=1, WriteRegW=0, ALUResultW=0xFFFFFFFF.
- Expected: RD1D(RA1D=0)=0 before and after the edge; WBCount unchanged.
REQ-035 Bypass:
- Setup: r7=0x11111111.
- Same cycle: write r7=0x22222222 with RA1D=RA2D=7.
- Expected: RD1D=RD2D=0x22222222 before the edge, and the same after it.
REQ-036 Counter wrap: preload 0xFFFFFFFF effective writes (or force WBCount=0xFFFFFFFF), then one more write -> WBCount=0.
REQ-037 Disabled write: RegWriteW=0, WriteRegW=3, ALUResultW=0x5 -> r3 keeps its prior value; WBCount unchanged.
